// File: rtl/clock_mode_ctrl.sv
// clock_mode_ctrl
//   Timekeeping core and display/set mode sequencer for the timekeeper display path.
//   It counts hh:mm:ss from a 1 Hz tick. It runs a four-state mode machine
//   (RUN_HM, SET_HM, RUN_MS, SET_MS) from three debounced button pulses.
//   In the set states it provides field-select and blink flags for the display stage.
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high
//   tick_1hz   one-cycle pulse per second
//   btn_mode   one-cycle pulse: toggle view (run) / toggle edited field (set)
//   btn_sel    one-cycle pulse: enter / leave set state
//   btn_inc    one-cycle pulse: increment edited field (set only)
//   state      mode: 0 RUN_HM, 1 SET_HM, 2 RUN_MS, 3 SET_MS
//   seconds    0..59
//   minutes    0..59
//   hours      0..23
//   field_sel  edited field: 0 low, 1 high
//   blink      toggles per tick in set states, 0 in run states
module clock_mode_ctrl #(
  parameter int unsigned TIMEOUT_TICKS = 10,
  parameter int unsigned TIMEOUT_W     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_sel,
  input  logic       btn_inc,
  output logic [1:0] state,
  output logic [5:0] seconds,
  output logic [5:0] minutes,
  output logic [4:0] hours,
  output logic       field_sel,
  output logic       blink
);

  localparam int unsigned SEC_W = 6;
  localparam int unsigned HRS_W = 5;

  typedef enum logic [1:0] {
    RUN_HM = 2'd0,
    SET_HM = 2'd1,
    RUN_MS = 2'd2,
    SET_MS = 2'd3
  } mode_e;

  mode_e                 state_q, state_n;
  logic [SEC_W-1:0]      sec_n, min_n;
  logic [HRS_W-1:0]      hrs_n;
  logic                  field_n, blink_n;
  logic [TIMEOUT_W-1:0]  cnt_q, cnt_n;
  logic                  btn_any;

  // Modulo-60 increment without carry-out
  function automatic logic [SEC_W-1:0] wrap60(input logic [SEC_W-1:0] v);
    return (v == SEC_W'(59)) ? '0 : v + SEC_W'(1);
  endfunction

  // Modulo-24 increment
  function automatic logic [HRS_W-1:0] wrap24(input logic [HRS_W-1:0] v);
    return (v == HRS_W'(23)) ? '0 : v + HRS_W'(1);
  endfunction

  assign btn_any = btn_sel | btn_mode | btn_inc;
  assign state   = state_q;

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN_HM;
      seconds   <= '0;
      minutes   <= '0;
      hours     <= '0;
      field_sel <= 1'b0;
      blink     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_n;
      seconds   <= sec_n;
      minutes   <= min_n;
      hours     <= hrs_n;
      field_sel <= field_n;
      blink     <= blink_n;
      cnt_q     <= cnt_n;
    end
  end

  // Next-state, time and flag logic
  always_comb begin
    state_n = state_q;
    sec_n   = seconds;
    min_n   = minutes;
    hrs_n   = hours;
    field_n = field_sel;
    blink_n = blink;
    cnt_n   = cnt_q;

    case (state_q)
      RUN_HM, RUN_MS: begin
        blink_n = 1'b0;
        if (btn_sel) begin
          state_n = (state_q == RUN_HM) ? SET_HM : SET_MS;
          field_n = 1'b0;
          cnt_n   = '0;
        end else if (btn_mode) begin
          state_n = (state_q == RUN_HM) ? RUN_MS : RUN_HM;
        end
        // Time advances in run states regardless of any button in the same cycle
        if (tick_1hz) begin
          sec_n = wrap60(seconds);
          if (seconds == SEC_W'(59)) begin
            min_n = wrap60(minutes);
            if (minutes == SEC_W'(59)) begin
              hrs_n = wrap24(hours);
            end
          end
        end
      end

      default: begin
        if (btn_sel) begin
          state_n = (state_q == SET_HM) ? RUN_HM : RUN_MS;
          field_n = 1'b0;
          blink_n = 1'b0;
          cnt_n   = '0;
        end else if (btn_mode) begin
          field_n = ~field_sel;
          cnt_n   = '0;
        end else if (btn_inc) begin
          cnt_n = '0;
          if (state_q == SET_HM) begin
            if (field_sel) hrs_n = wrap24(hours);
            else           min_n = wrap60(minutes);
          end else begin
            if (field_sel) min_n = wrap60(minutes);
            else           sec_n = wrap60(seconds);
          end
        end
        // A button in the tick cycle beats the timeout; leaving via btn_sel keeps blink at 0
        if (tick_1hz && !btn_sel) begin
          if (btn_any) begin
            blink_n = ~blink;
          end else if (cnt_q == TIMEOUT_W'(TIMEOUT_TICKS - 1)) begin
            state_n = (state_q == SET_HM) ? RUN_HM : RUN_MS;
            field_n = 1'b0;
            blink_n = 1'b0;
            cnt_n   = '0;
          end else begin
            blink_n = ~blink;
            cnt_n   = cnt_q + TIMEOUT_W'(1);
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Testbench for clock_mode_ctrl: directed stimulus pushes hand-computed
// expected outputs into a scoreboard queue; a monitor pops one entry per
// clock edge and compares.
module tb_clock_mode_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_sel = 1'b0;
  logic       btn_inc = 1'b0;
  logic [1:0] state;
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic [4:0] hours;
  logic       field_sel;
  logic       blink;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit         chk;
    bit         cb;      // compare blink
    string      name;
    logic [1:0] st;
    logic [5:0] s;
    logic [5:0] m;
    logic [4:0] h;
    logic       f;
    logic       b;
  } exp_t;

  exp_t sb[$];

  clock_mode_ctrl #(.TIMEOUT_TICKS(10), .TIMEOUT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .tick_1hz  (tick_1hz),
    .btn_mode  (btn_mode),
    .btn_sel   (btn_sel),
    .btn_inc   (btn_inc),
    .state     (state),
    .seconds   (seconds),
    .minutes   (minutes),
    .hours     (hours),
    .field_sel (field_sel),
    .blink     (blink)
  );

  always #5 clk = ~clk;

  function automatic exp_t nochk();
    exp_t e;
    e.chk = 1'b0; e.cb = 1'b0; e.name = "";
    e.st = '0; e.s = '0; e.m = '0; e.h = '0; e.f = 1'b0; e.b = 1'b0;
    return e;
  endfunction

  function automatic exp_t ex(input string n, input int st, input int s, input int m,
                              input int h, input int f, input int b, input bit cb = 1'b1);
    exp_t e;
    e.chk = 1'b1; e.cb = cb; e.name = n;
    e.st = 2'(st); e.s = 6'(s); e.m = 6'(m); e.h = 5'(h); e.f = 1'(f); e.b = 1'(b);
    return e;
  endfunction

  // One clock of stimulus; the expectation describes outputs after that edge
  task automatic cyc(input bit t, input bit md, input bit sl, input bit in, input bit rs,
                     input exp_t e);
    @(negedge clk);
    tick_1hz = t; btn_mode = md; btn_sel = sl; btn_inc = in; reset = rs;
    sb.push_back(e);
  endtask

  // n back-to-back btn_inc pulses; the last carries the expectation
  task automatic incs(input int n, input exp_t e);
    for (int i = 1; i <= n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, (i == n) ? e : nochk());
  endtask

  task automatic check(input exp_t e);
    logic gb, wb;
    gb = e.cb ? blink : 1'b0;
    wb = e.cb ? e.b : 1'b0;
    n_cmp++;
    if ({state, seconds, minutes, hours, field_sel, gb} !== {e.st, e.s, e.m, e.h, e.f, wb}) begin
      n_bad++;
      $display("FAIL %s: got st=%0d %0d:%0d:%0d f=%0d b=%0d, want st=%0d %0d:%0d:%0d f=%0d b=%0d",
               e.name, state, hours, minutes, seconds, field_sel, gb,
               e.st, e.h, e.m, e.s, e.f, wb);
    end
  endtask

  // Monitor: outputs are valid every cycle, one scoreboard entry per edge
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (e.chk) check(e);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    exp_t e;
    // Reset overrides all inputs
    cyc(1, 1, 1, 1, 1, ex("reset", 0, 0, 0, 0, 0, 0));
    cyc(0, 0, 0, 0, 0, ex("idle", 0, 0, 0, 0, 0, 0));

    // 3661 ticks in RUN_HM
    for (int k = 1; k <= 3661; k++) begin
      if (k == 60)        e = ex("t1_min_carry", 0, 0, 1, 0, 0, 0);
      else if (k == 3600) e = ex("t1_hr_carry", 0, 0, 0, 1, 0, 0);
      else if (k == 3661) e = ex("t1_3661", 0, 1, 1, 1, 0, 0);
      else                e = nochk();
      cyc(1, 0, 0, 0, 0, e);
    end

    // Preload 23:59:58 through the set path, then roll over midnight
    cyc(0, 0, 0, 0, 1, ex("t2_reset", 0, 0, 0, 0, 0, 0));
    cyc(0, 0, 1, 0, 0, ex("t2_enter_set_hm", 1, 0, 0, 0, 0, 0));
    cyc(0, 1, 0, 0, 0, ex("t2_sel_hours", 1, 0, 0, 0, 1, 0));
    incs(23, ex("t2_hours_23", 1, 0, 0, 23, 1, 0));
    incs(1,  ex("t2_hours_wrap", 1, 0, 0, 0, 1, 0));
    incs(23, ex("t2_hours_23b", 1, 0, 0, 23, 1, 0));
    cyc(0, 1, 0, 0, 0, ex("t2_sel_minutes", 1, 0, 0, 23, 0, 0));
    incs(60, ex("t2_min_wrap_nocarry", 1, 0, 0, 23, 0, 0));
    incs(59, ex("t2_min_59", 1, 0, 59, 23, 0, 0));
    cyc(0, 0, 1, 0, 0, ex("t2_exit_set_hm", 0, 0, 59, 23, 0, 0));
    cyc(0, 1, 0, 0, 0, ex("t2_view_ms", 2, 0, 59, 23, 0, 0));
    cyc(0, 0, 1, 0, 0, ex("t2_enter_set_ms", 3, 0, 59, 23, 0, 0));
    incs(60, ex("t2_sec_wrap_nocarry", 3, 0, 59, 23, 0, 0));
    incs(58, ex("t2_sec_58", 3, 58, 59, 23, 0, 0));
    cyc(0, 0, 1, 0, 0, ex("t2_exit_set_ms", 2, 58, 59, 23, 0, 0));
    cyc(1, 0, 0, 0, 0, ex("t2_235959", 2, 59, 59, 23, 0, 0));
    cyc(1, 0, 0, 0, 0, ex("t2_midnight", 2, 0, 0, 0, 0, 0));

    // Edit hours/minutes with ticks interleaved; seconds stay frozen
    cyc(0, 0, 0, 0, 1, ex("t3_reset", 0, 0, 0, 0, 0, 0));
    cyc(0, 0, 1, 0, 0, ex("t3_enter", 1, 0, 0, 0, 0, 0));
    cyc(1, 0, 0, 0, 0, ex("t3_tick_frozen", 1, 0, 0, 0, 0, 1));
    incs(5,  ex("t3_min_5", 1, 0, 5, 0, 0, 1));
    cyc(1, 0, 0, 0, 0, ex("t3_tick2", 1, 0, 5, 0, 0, 0));
    cyc(0, 1, 0, 0, 0, ex("t3_field_hi", 1, 0, 5, 0, 1, 0));
    incs(24, ex("t3_hours_wrap", 1, 0, 5, 0, 1, 0));
    incs(1,  ex("t3_hours_1", 1, 0, 5, 1, 1, 0));
    cyc(1, 0, 0, 0, 0, ex("t3_tick3", 1, 0, 5, 1, 1, 1));
    cyc(0, 0, 1, 0, 0, ex("t3_done", 0, 0, 5, 1, 0, 0));

    // Timeout in SET_MS, then restart of the count by a button on a tick
    cyc(0, 1, 0, 0, 0, ex("t4_view_ms", 2, 0, 5, 1, 0, 0));
    cyc(0, 0, 1, 0, 0, ex("t4_enter", 3, 0, 5, 1, 0, 0));
    for (int k = 1; k <= 9; k++)
      cyc(1, 0, 0, 0, 0, (k == 9) ? ex("t4_tick9", 3, 0, 5, 1, 0, 1) : nochk());
    cyc(1, 0, 0, 0, 0, ex("t4_timeout", 2, 0, 5, 1, 0, 0));
    cyc(0, 0, 1, 0, 0, ex("t4_reenter", 3, 0, 5, 1, 0, 0));
    for (int k = 1; k <= 8; k++) cyc(1, 0, 0, 0, 0, nochk());
    cyc(1, 0, 0, 1, 0, ex("t4_inc_on_tick9", 3, 1, 5, 1, 0, 0, 1'b0));
    for (int k = 1; k <= 9; k++)
      cyc(1, 0, 0, 0, 0, (k == 9) ? ex("t4_no_early_timeout", 3, 1, 5, 1, 0, 0, 1'b0) : nochk());
    cyc(1, 0, 0, 0, 0, ex("t4_timeout_restart", 2, 1, 5, 1, 0, 0));
    cyc(1, 0, 0, 0, 0, ex("t4_run_tick", 2, 2, 5, 1, 0, 0));
    cyc(1, 1, 0, 0, 0, ex("run_mode_with_tick", 0, 3, 5, 1, 0, 0));

    // All three buttons in RUN_HM: only btn_sel acts
    cyc(0, 1, 1, 1, 0, ex("t5_priority", 1, 3, 5, 1, 0, 0));

    // Reset in the middle of an edit
    incs(37, ex("t6_min_42", 1, 3, 42, 1, 0, 0));
    cyc(1, 0, 0, 0, 0, ex("t6_blink", 1, 3, 42, 1, 0, 1));
    cyc(1, 1, 0, 1, 1, ex("t6_reset_in_set", 0, 0, 0, 0, 0, 0));
    cyc(1, 0, 1, 0, 0, ex("run_sel_with_tick", 1, 1, 0, 0, 0, 0));
    cyc(0, 0, 0, 0, 0, nochk());

    // Drain the scoreboard
    for (int w = 0; w < 10 && sb.size() != 0; w++) @(posedge clk);
    #2;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d entries left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clock_mode_ctrl.md
# clock_mode_ctrl

Mode sequencer and timekeeping core for the timekeeper display path. Counts hours/minutes/seconds from a one-cycle 1 Hz tick, runs the four-state display/set mode machine from three debounced button pulses, and drives the `state`, `seconds`, `minutes` and `hours` inputs of the BCD digit splitter. It also produces the field-select and blink flags the display stage uses to flash the field being edited.

## Interface

- `TIMEOUT_TICKS`, default 10: number of 1 Hz ticks with no button activity after which a set state returns to its run state.
- `TIMEOUT_W`, default 4: width of the timeout counter. It must hold `TIMEOUT_TICKS`.
- `clk` in, 1 bit: system clock. All logic is on the rising edge.
- `reset` in, 1 bit: synchronous, active-high reset.
- `tick_1hz` in, 1 bit: one-cycle pulse once per second.
- `btn_mode` in, 1 bit: one-cycle debounced pulse.
- `btn_sel` in, 1 bit: one-cycle debounced pulse.
- `btn_inc` in, 1 bit: one-cycle debounced pulse.
- `state` out, 2 bits: display/set mode. Encoding: 0 = RUN_HM, 1 = SET_HM, 2 = RUN_MS, 3 = SET_MS.
- `seconds` out, 6 bits: 0..59.
- `minutes` out, 6 bits: 0..59.
- `hours` out, 5 bits: 0..23.
- `field_sel` out, 1 bit: field being edited. 0 = low field, 1 = high field.
  - In SET_HM the low field is minutes and the high field is hours.
  - In SET_MS the low field is seconds and the high field is minutes.
- `blink` out, 1 bit: toggles on every `tick_1hz` while in a set state. Held at 0 in run states.

## Operation

- All outputs are registered.
- Reset values: `state`=0 (RUN_HM), `seconds`=0, `minutes`=0, `hours`=0, `field_sel`=0, `blink`=0. The timeout counter is also cleared to 0.
- Button priority, with exactly one action per cycle: `btn_sel` > `btn_mode` > `btn_inc`. Lower-priority pulses arriving in the same cycle are dropped.
- **RUN_HM / RUN_MS**
  - `btn_sel` goes to the matching set state (0→1, 2→3). It also clears `field_sel`, the timeout counter and `blink`.
  - `btn_mode` toggles the view: 0↔2.
  - `btn_inc` is ignored.
  - `tick_1hz` advances time:
    - `seconds`+1. When `seconds` is 59 it wraps to 0 and `minutes`+1.
    - When `minutes` is 59 it wraps to 0 and `hours`+1.
    - When `hours` is 23 it wraps to 0.
    - 23:59:59 + tick gives 00:00:00.
- **SET_HM / SET_MS**
  - Time is frozen: `tick_1hz` does not advance any counter.
  - `btn_sel` returns to the matching run state (1→0, 3→2). It also clears `field_sel` and `blink`.
  - `btn_mode` toggles `field_sel`.
  - `btn_inc` adds 1 to the selected field, with wrap and no carry:
    - seconds and minutes go 59→0, and the neighbouring field is unchanged;
    - hours go 23→0.
  - Any of the three button pulses clears the timeout counter.
  - `tick_1hz` toggles `blink` and increments the timeout counter. When the tick would bring the counter to `TIMEOUT_TICKS`:
    - the block returns to the matching run state and clears `field_sel`, `blink` and the counter;
    - this tick does not advance time.
  - A button pulse in the same cycle as a tick takes precedence over the timeout. The button action is taken and the counter is cleared.
- The `state` encoding never leaves 0..3. There is no illegal-state recovery beyond reset.

## Timing

- Single clock domain. Inputs are sampled at a rising edge, and the result is visible on the outputs at that same edge (1-cycle latency).
- The digit splitter adds one more register stage, so a BCD digit changes 2 cycles after the input pulse.
- Back-to-back pulses on consecutive cycles are each acted on. There is no minimum spacing.
- Reset is taken at the edge where `reset`=1 and overrides every other input in that cycle. A reset in the middle of a set operation discards the edit and returns to 00:00:00, RUN_HM.
- `tick_1hz` and a button in the same cycle in a run state: the button action and the time advance both happen. Example: `btn_mode` together with a tick both switches the view and advances `seconds`.

## Test plan

1. Reset, then issue 3661 ticks in RUN_HM → `hours`=1, `minutes`=1, `seconds`=1, `state`=0.
2. Preload 23:59:58 via the set path, return to RUN, issue 2 ticks → 00:00:00 with no spurious intermediate value.
3. From RUN_HM: `btn_sel`, 5× `btn_inc`, `btn_mode`, 25× `btn_inc`, `btn_sel` → `state`=0, `hours`=1, `minutes`=5. Ticks issued during the edit leave `seconds` unchanged.
4. Enter SET_MS and issue 10 ticks with no buttons → `state` returns to 2 on the 10th tick and `blink`=0. A `btn_inc` arriving together with the 9th tick restarts the count, so the return happens 10 ticks after that.
5. `btn_sel`, `btn_mode` and `btn_inc` all asserted in the same cycle in RUN_HM → `state`=1 only, no view change.
6. Assert `reset` in SET_HM with `minutes`=42 → the next cycle shows `state`=0, all counters 0, `field_sel`=0, `blink`=0.
